// File: rtl/mem_access_unit_if.sv
// Bundle of the MEM-stage request/response and Memory-port signals of mem_access_unit.
// slave is the unit side; master is the pipeline/Memory side.
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic        sb_empty;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_dout,
        output req_ready, rsp_valid, rsp_rdata, mem_ren, mem_wen, mem_addr, mem_din, sb_empty
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_dout,
        input  req_ready, rsp_valid, rsp_rdata, mem_ren, mem_wen, mem_addr, mem_din, sb_empty
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: store buffer with youngest-match load forwarding, draining
// one store per WR visit and servicing load misses with a single RD cycle.
module mem_access_unit #(
    parameter int DEPTH = 4
) (
    input  logic               clock,
    input  logic               reset,
    mem_access_unit_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WR   = 2'd1;
    localparam logic [1:0] RD   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [AW:0]   count_q;
    logic [AW-1:0] head_q, tail_q;
    logic [31:0]   sb_addr_q [DEPTH];
    logic [31:0]   sb_data_q [DEPTH];
    logic [31:0]   ld_addr_q;
    logic [31:0]   rsp_rdata_q;
    logic          rsp_valid_q;

    logic          full, accept, push;
    logic [DEPTH-1:0] entry_live, entry_hit;
    logic          fwd_hit;
    logic [31:0]   fwd_data;
    logic [AW-1:0] fwd_idx;

    assign full   = (count_q == (AW+1)'(DEPTH));
    assign bus.req_ready = (state_q == IDLE) && !full;
    assign accept = bus.req_valid && bus.req_ready;
    assign push   = accept && bus.req_we;

    // An entry is live when its distance from head is below the occupancy count.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            localparam logic [AW-1:0] IDX = AW'(gi);
            logic [AW-1:0] age;
            assign age            = IDX - head_q;
            assign entry_live[gi] = ({1'b0, age} < count_q);
            assign entry_hit[gi]  = entry_live[gi] && (sb_addr_q[gi] == bus.req_addr);
        end
    endgenerate

    // Scan oldest to youngest so the last match seen is the youngest store.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head_q + AW'(k);
            if (entry_hit[fwd_idx]) begin
                fwd_hit  = 1'b1;
                fwd_data = sb_data_q[fwd_idx];
            end
        end
    end

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE: begin
                if (full)
                    state_d = WR;
                else if (accept && !bus.req_we && !fwd_hit)
                    state_d = RD;
                else if (!accept && count_q != '0)
                    state_d = WR;
                else
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            ld_addr_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= 1'b0;
            if (push) begin
                tail_q  <= tail_q + 1'b1;
                count_q <= count_q + 1'b1;
            end else if (state_q == WR) begin
                head_q  <= head_q + 1'b1;
                count_q <= count_q - 1'b1;
            end
            if (accept && !bus.req_we) begin
                if (fwd_hit) begin
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= fwd_data;
                end else begin
                    ld_addr_q <= bus.req_addr;
                end
            end
            if (state_q == RD) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= bus.mem_dout;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            sb_addr_q[tail_q] <= bus.req_addr;
            sb_data_q[tail_q] <= bus.req_wdata;
        end
    end

    // Memory strobes are masked by reset so an access caught by reset never lands.
    assign bus.mem_wen  = (state_q == WR) && !reset;
    assign bus.mem_ren  = (state_q == RD) && !reset;
    assign bus.mem_addr = bus.mem_wen ? sb_addr_q[head_q] :
                          bus.mem_ren ? ld_addr_q : '0;
    assign bus.mem_din  = bus.mem_wen ? sb_data_q[head_q] : '0;

    assign bus.sb_empty  = (count_q == '0);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus a random load/store mix, checked
// by a scoreboard against an architectural memory model.
module tb_mem_access_unit;
    logic clock = 1'b0;
    logic reset = 1'b1;

    mem_access_unit_if ifc ();

    mem_access_unit #(.DEPTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clock = ~clock;

    // Physical Memory: word i initially holds i; written on mem_wen at the clock edge.
    logic [31:0] phys [64];
    bit          mem_init_done = 1'b0;
    assign ifc.mem_dout = phys[ifc.mem_addr[5:0]];

    always @(posedge clock) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 64; i++) phys[i] <= 32'(i);
            mem_init_done <= 1'b1;
        end else if (ifc.mem_wen) begin
            phys[ifc.mem_addr[5:0]] <= ifc.mem_din;
        end
    end

    // Architectural view: what a load must return, given every accepted store so far.
    logic [31:0] arch [64];
    logic [31:0] ld_q [$];
    logic [63:0] st_q [$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit ren_seen = 1'b0;

    always @(posedge clock) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expected load data / drained stores whenever the DUT presents them.
    always @(negedge clock) begin
        if (ifc.mem_ren && ifc.mem_wen) begin
            n_bad++;
            $display("FAIL mem_strobes: mem_ren and mem_wen both 1 (cycle %0d)", cyc);
        end
        if (ifc.mem_ren) ren_seen = 1'b1;
        if (ifc.rsp_valid) begin
            if (ld_q.size() == 0) begin
                n_bad++;
                $display("FAIL spurious_rsp: rsp_valid=1 data %h with no load pending", ifc.rsp_rdata);
            end else begin
                chk("load_data", ifc.rsp_rdata, ld_q.pop_front());
            end
        end
        if (ifc.mem_wen) begin
            if (st_q.size() == 0) begin
                n_bad++;
                $display("FAIL spurious_write: addr %h data %h with no store pending", ifc.mem_addr, ifc.mem_din);
            end else begin
                logic [63:0] e;
                e = st_q.pop_front();
                chk("drain_addr", ifc.mem_addr, e[63:32]);
                chk("drain_data", ifc.mem_din, e[31:0]);
            end
        end
    end

    task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] d, output int acc_cyc);
        bit done = 1'b0;
        int waits = 0;
        acc_cyc = -1;
        ifc.req_valid = 1'b1;
        ifc.req_we    = we;
        ifc.req_addr  = a;
        ifc.req_wdata = d;
        while (!done) begin
            @(negedge clock);
            if (ifc.req_ready) begin
                if (we) begin
                    arch[a[5:0]] = d;
                    st_q.push_back({a, d});
                end else begin
                    ld_q.push_back(arch[a[5:0]]);
                end
                acc_cyc = cyc;
                done = 1'b1;
            end
            @(posedge clock); #1;
            waits++;
            if (!done && waits > 20) begin
                n_bad++;
                $display("FAIL req_timeout: request addr %h never accepted", a);
                done = 1'b1;
            end
        end
        ifc.req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clock);
            if (ifc.sb_empty && ifc.req_ready) ok = 1'b1;
        end
        if (!ok) begin
            n_bad++;
            $display("FAIL drain_timeout: store buffer not empty after 40 cycles");
        end
        @(posedge clock); #1;
    endtask

    initial begin
        int acc [5];
        int tmp;
        ifc.req_valid = 1'b0;
        ifc.req_we    = 1'b0;
        ifc.req_addr  = '0;
        ifc.req_wdata = '0;
        for (int i = 0; i < 64; i++) arch[i] = 32'(i);

        // Reset state, during and after reset.
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_during_wen", 32'(ifc.mem_wen), 32'd0);
        chk("rst_during_ren", 32'(ifc.mem_ren), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        chk("rst_sb_empty", 32'(ifc.sb_empty), 32'd1);
        chk("rst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", ifc.rsp_rdata, 32'd0);
        chk("rst_mem_addr", ifc.mem_addr, 32'd0);
        chk("rst_mem_din", ifc.mem_din, 32'd0);
        chk("rst_req_ready", 32'(ifc.req_ready), 32'd1);

        // Single store drains on the first idle cycle.
        do_req(1'b1, 32'h10, 32'hAAAA_0001, tmp);
        chk("st_idle_empty", 32'(ifc.sb_empty), 32'd0);
        @(posedge clock); #1;
        chk("wr_wen", 32'(ifc.mem_wen), 32'd1);
        chk("wr_ren", 32'(ifc.mem_ren), 32'd0);
        chk("wr_addr", ifc.mem_addr, 32'h10);
        chk("wr_din", ifc.mem_din, 32'hAAAA_0001);
        chk("wr_ready", 32'(ifc.req_ready), 32'd0);
        @(posedge clock); #1;
        chk("wr_sb_empty", 32'(ifc.sb_empty), 32'd1);
        chk("wr_memory", phys[16], 32'hAAAA_0001);

        // Youngest-store forwarding, no Memory read.
        ren_seen = 1'b0;
        do_req(1'b1, 32'h20, 32'd1, tmp);
        do_req(1'b1, 32'h20, 32'd2, tmp);
        do_req(1'b0, 32'h20, 32'd0, tmp);
        chk("fwd_valid", 32'(ifc.rsp_valid), 32'd1);
        chk("fwd_data", ifc.rsp_rdata, 32'd2);
        @(posedge clock); #1;
        chk("fwd_pulse", 32'(ifc.rsp_valid), 32'd0);
        wait_drain();
        chk("fwd_no_ren", 32'(ren_seen), 32'd0);
        chk("fwd_memory", phys[32], 32'd2);

        // Load miss: RD cycle, data two cycles after acceptance.
        do_req(1'b0, 32'h5, 32'd0, tmp);
        chk("rd_ren", 32'(ifc.mem_ren), 32'd1);
        chk("rd_addr", ifc.mem_addr, 32'h5);
        chk("rd_not_yet", 32'(ifc.rsp_valid), 32'd0);
        @(posedge clock); #1;
        chk("rd_valid", 32'(ifc.rsp_valid), 32'd1);
        chk("rd_data", ifc.rsp_rdata, 32'd5);
        wait_drain();

        // Full buffer: four back-to-back accepts, stall, one WR, then accept again.
        for (int i = 0; i < 5; i++) do_req(1'b1, 32'(8 + i), $urandom, acc[i]);
        chk("burst_accepts", 32'(acc[3] - acc[0]), 32'd3);
        chk("full_stall", 32'(acc[4] - acc[3]), 32'd3);
        wait_drain();

        // Reset during the first WR cycle discards both buffered stores.
        do_req(1'b1, 32'd30, 32'hDEAD_0030, tmp);
        do_req(1'b1, 32'd31, 32'hDEAD_0031, tmp);
        @(posedge clock); #1;
        chk("abort_in_wr", 32'(ifc.mem_wen), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_wen_masked", 32'(ifc.mem_wen), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        st_q.delete();
        ld_q.delete();
        chk("abort_sb_empty", 32'(ifc.sb_empty), 32'd1);
        chk("abort_wen", 32'(ifc.mem_wen), 32'd0);
        chk("abort_rsp", 32'(ifc.rsp_valid), 32'd0);
        repeat (4) @(posedge clock);
        #1;
        chk("abort_first_dropped", phys[30], 32'd30);
        chk("abort_second_dropped", phys[31], 32'd31);
        for (int i = 0; i < 64; i++) arch[i] = phys[i];

        // Random mix over 16 addresses.
        for (int n = 0; n < 1000; n++) begin
            do_req(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom, tmp);
            repeat ($urandom_range(0, 2)) @(posedge clock);
            #1;
        end
        wait_drain();
        repeat (3) @(posedge clock);
        #1;
        chk("loads_outstanding", 32'(ld_q.size()), 32'd0);
        chk("stores_outstanding", 32'(st_q.size()), 32'd0);
        for (int i = 0; i < 16; i++) chk("final_memory", phys[i], arch[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
